// File: rtl/ttt_board_ctrl.sv
// ttt_board_ctrl: tic-tac-toe game-state controller feeding and consuming winner_detector
module ttt_board_ctrl #(
    parameter logic [1:0] FIRST_PLAYER   = 2'd1,
    parameter int         TIMEOUT_CYCLES = 0,
    parameter int         TO_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_idx,
    input  logic       win_in,
    input  logic [1:0] who_in,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic       move_ready,
    output logic [1:0] turn,
    output logic [3:0] move_count,
    output logic       illegal_move,
    output logic       timeout,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw
);
    typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;
    state_t            state, state_nx;
    logic [8:0][1:0]   cells, cells_nx;
    logic [1:0]        turn_nx, winner_nx, other;
    logic [3:0]        count_nx;
    logic              ill_nx, to_nx, go_nx, draw_nx;
    logic [TO_W-1:0]   to_cnt, to_cnt_nx;
    logic              occupied, idx_ok, legal, to_hit;
    assign {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1} = cells;
    assign move_ready = (state == PLAY);
    assign idx_ok     = (move_idx >= 4'd1) && (move_idx <= 4'd9);
    assign legal      = move_valid && idx_ok && !occupied;
    assign other      = (turn == 2'd1) ? 2'd2 : 2'd1;
    assign to_hit     = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    always_comb begin
        occupied = 1'b0;
        for (int i = 0; i < 9; i++)
            occupied = occupied | ((move_idx == 4'(i + 1)) && (cells[i] != 2'd0));
    end
    always_comb begin
        state_nx  = state;
        cells_nx  = cells;
        turn_nx   = turn;
        count_nx  = move_count;
        ill_nx    = 1'b0;
        to_nx     = 1'b0;
        go_nx     = game_over;
        winner_nx = winner;
        draw_nx   = draw;
        to_cnt_nx = to_cnt;
        if (new_game) begin
            state_nx  = PLAY;
            cells_nx  = '0;
            turn_nx   = FIRST_PLAYER;
            count_nx  = 4'd0;
            go_nx     = 1'b0;
            winner_nx = 2'd0;
            draw_nx   = 1'b0;
            to_cnt_nx = '0;
        end else begin
            unique case (state)
                PLAY: begin
                    if (legal) begin
                        for (int i = 0; i < 9; i++)
                            if (move_idx == 4'(i + 1)) cells_nx[i] = turn;
                        count_nx  = (move_count == 4'd9) ? 4'd9 : move_count + 4'd1;
                        to_cnt_nx = '0;
                        state_nx  = CHECK;
                    end else begin
                        ill_nx = move_valid;
                        // a legal move in the same cycle always beats a forfeit
                        if (to_hit) begin
                            turn_nx   = other;
                            to_nx     = 1'b1;
                            to_cnt_nx = '0;
                        end else if (TIMEOUT_CYCLES != 0) begin
                            to_cnt_nx = to_cnt + TO_W'(1);
                        end
                    end
                end
                CHECK: begin
                    if (win_in) begin
                        winner_nx = who_in;
                        go_nx     = 1'b1;
                        state_nx  = DONE;
                    end else if (move_count == 4'd9) begin
                        draw_nx  = 1'b1;
                        go_nx    = 1'b1;
                        state_nx = DONE;
                    end else begin
                        turn_nx  = other;
                        state_nx = PLAY;
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= PLAY;
            cells        <= '0;
            turn         <= FIRST_PLAYER;
            move_count   <= 4'd0;
            illegal_move <= 1'b0;
            timeout      <= 1'b0;
            game_over    <= 1'b0;
            winner       <= 2'd0;
            draw         <= 1'b0;
            to_cnt       <= '0;
        end else begin
            state        <= state_nx;
            cells        <= cells_nx;
            turn         <= turn_nx;
            move_count   <= count_nx;
            illegal_move <= ill_nx;
            timeout      <= to_nx;
            game_over    <= go_nx;
            winner       <= winner_nx;
            draw         <= draw_nx;
            to_cnt       <= to_cnt_nx;
        end
    end
endmodule

// File: tb/tb_ttt_board_ctrl.sv
// tb_ttt_board_ctrl: scoreboard bench for ttt_board_ctrl with a behavioural winner detector
module tb_ttt_board_ctrl;
    logic       clk, rst_n, new_game, move_valid;
    logic [3:0] move_idx;
    logic       win_in;
    logic [1:0] who_in;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic       move_ready, illegal_move, timeout, game_over, draw;
    logic [1:0] turn, winner;
    logic [3:0] move_count;
    logic       rst2_n;
    logic [1:0] t_pos [9];
    logic       t_ready, t_ill, t_to, t_go, t_draw;
    logic [1:0] t_turn, t_winner;
    logic [3:0] t_count;
    ttt_board_ctrl dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
        .move_idx(move_idx), .win_in(win_in), .who_in(who_in),
        .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
        .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
        .move_ready(move_ready), .turn(turn), .move_count(move_count),
        .illegal_move(illegal_move), .timeout(timeout), .game_over(game_over),
        .winner(winner), .draw(draw)
    );
    ttt_board_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst_n(rst2_n), .new_game(1'b0), .move_valid(1'b0),
        .move_idx(4'd0), .win_in(1'b0), .who_in(2'd0),
        .pos1(t_pos[0]), .pos2(t_pos[1]), .pos3(t_pos[2]), .pos4(t_pos[3]), .pos5(t_pos[4]),
        .pos6(t_pos[5]), .pos7(t_pos[6]), .pos8(t_pos[7]), .pos9(t_pos[8]),
        .move_ready(t_ready), .turn(t_turn), .move_count(t_count),
        .illegal_move(t_ill), .timeout(t_to), .game_over(t_go),
        .winner(t_winner), .draw(t_draw)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    logic [1:0] b [9];
    assign b = '{pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    always_comb begin
        win_in = 1'b0;
        who_in = 2'd0;
        for (int l = 0; l < 8; l++)
            if (b[lines[l][0]] != 2'd0 && b[lines[l][0]] == b[lines[l][1]] && b[lines[l][0]] == b[lines[l][2]]) begin
                win_in = 1'b1;
                who_in = b[lines[l][0]];
            end
    end
    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb [$];
    int n_chk = 0;
    int n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [31:0] obs(input string tag);
        case (tag)
            "pos1":    return 32'(pos1);
            "pos2":    return 32'(pos2);
            "pos3":    return 32'(pos3);
            "pos4":    return 32'(pos4);
            "pos5":    return 32'(pos5);
            "pos6":    return 32'(pos6);
            "pos9":    return 32'(pos9);
            "board":   return 32'({pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1});
            "turn":    return 32'(turn);
            "count":   return 32'(move_count);
            "ready":   return 32'(move_ready);
            "ill":     return 32'(illegal_move);
            "to":      return 32'(timeout);
            "go":      return 32'(game_over);
            "winner":  return 32'(winner);
            "draw":    return 32'(draw);
            "t_to":    return 32'(t_to);
            "t_turn":  return 32'(t_turn);
            "t_board": return 32'({t_pos[8], t_pos[7], t_pos[6], t_pos[5], t_pos[4], t_pos[3], t_pos[2], t_pos[1], t_pos[0]});
            default:   return 32'hdead_beef;
        endcase
    endfunction
    task automatic want(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.tag), e.val);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask
    task automatic play(input logic [3:0] idx);
        move_valid = 1'b1;
        move_idx   = idx;
        tick();
        move_valid = 1'b0;
        tick();
    endtask
    task automatic restart();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
    initial begin
        rst_n = 1'b0; rst2_n = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_idx = 4'd0;
        @(posedge clk); #1;
        want("board", 0); want("turn", 1); want("count", 0); want("ready", 1);
        want("ill", 0); want("to", 0); want("go", 0); want("winner", 0); want("draw", 0);
        drain();
        @(posedge clk); #1;
        rst_n = 1'b1;
        // X wins on the top row; moves held through CHECK and DONE are ignored
        play(4'd1); play(4'd4); play(4'd2); play(4'd5);
        move_valid = 1'b1; move_idx = 4'd3;
        want("ready", 0); want("count", 5); want("pos3", 1);
        tick();
        move_idx = 4'd6;
        want("winner", 1); want("go", 1); want("ill", 0); want("pos6", 0); want("ready", 0);
        tick();
        want("pos1", 1); want("pos2", 1); want("pos3", 1); want("pos4", 2); want("pos5", 2);
        want("count", 5); want("ill", 0); want("pos6", 0); want("draw", 0); want("turn", 1);
        tick();
        new_game = 1'b1;
        want("board", 0); want("turn", 1); want("go", 0); want("count", 0);
        want("winner", 0); want("ready", 1); want("pos6", 0);
        tick();
        new_game = 1'b0; move_valid = 1'b0;
        // occupied cell and out-of-range index
        play(4'd1);
        move_valid = 1'b1; move_idx = 4'd1;
        want("ill", 1); want("turn", 2); want("count", 1); want("pos1", 1); want("ready", 1);
        tick();
        move_valid = 1'b0;
        want("ill", 0);
        tick();
        move_valid = 1'b1; move_idx = 4'd0;
        want("ill", 1); want("board", 1); want("turn", 2);
        tick();
        move_idx = 4'd12;
        want("ill", 1); want("count", 1);
        tick();
        move_valid = 1'b0;
        want("ill", 0);
        tick();
        // full board without a line
        restart();
        play(4'd1); play(4'd3); play(4'd2); play(4'd5); play(4'd7);
        play(4'd4); play(4'd6); play(4'd8);
        move_valid = 1'b1; move_idx = 4'd9;
        tick();
        move_valid = 1'b0;
        want("draw", 1); want("winner", 0); want("go", 1); want("count", 9);
        want("turn", 1); want("pos9", 1);
        tick();
        // asynchronous reset between edges
        restart();
        play(4'd1); play(4'd2); play(4'd3);
        want("count", 3);
        drain();
        #2 rst_n = 1'b0;
        #1;
        want("count", 0); want("board", 0); want("turn", 1); want("ready", 1);
        want("go", 0);
        drain();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        play(4'd5);
        want("pos5", 1); want("count", 1); want("turn", 2); want("ready", 1);
        drain();
        // forfeit timing on the TIMEOUT_CYCLES=4 instance
        @(posedge clk); #1;
        rst2_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            want("t_to", (k == 4 || k == 8) ? 1 : 0);
            want("t_turn", (k >= 4 && k < 8) ? 2 : 1);
            want("t_board", 0);
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ttt_board_ctrl.md
Name: ttt_board_ctrl

Overview:
- Game-state controller that sits directly upstream of winner_detector.
- Accepts player moves, validates them, and stores the nine 2-bit cells. It drives pos1..pos9 into winner_detector.
- Consumes the combinational win/who result one cycle after each accepted move and decides win, draw or next turn.
- Alternates turns and can forfeit a turn on an optional move timeout.

Parameters:
- FIRST_PLAYER, 2'd1: player that moves first after reset or new_game (1 = X, 2 = O).
- TIMEOUT_CYCLES, 0: number of PLAY-state cycles without a legal move before the turn is forfeited; 0 disables the timeout.
- TO_W, 16: width of the timeout counter; TIMEOUT_CYCLES must be below 2^TO_W.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- new_game  in  1  synchronous clear/restart, single-cycle pulse
- move_valid  in  1  move request
- move_idx  in  4  target cell 1..9 (1 = top-left, row-major)
- win_in  in  1  from winner_detector.win
- who_in  in  2  from winner_detector.who
- pos1..pos9  out  2 each  cell contents: 0 empty, 1 X, 2 O; 3 never driven
- move_ready  out  1  high only in PLAY
- turn  out  2  player to move (1 or 2)
- move_count  out  4  accepted moves, 0..9
- illegal_move  out  1  one-cycle pulse on a rejected request
- timeout  out  1  one-cycle pulse on a forfeited turn
- game_over  out  1  level, high in DONE
- winner  out  2  0 none, else winning player
- draw  out  1  level, board full with no win

Behaviour:
Reset (rst_n low, asynchronous):
- pos* = 0, turn = FIRST_PLAYER, move_count = 0.
- illegal_move, timeout, game_over, winner and draw = 0.
- State = PLAY, timeout counter = 0.

FSM has three states: PLAY, CHECK, DONE.

PLAY (move_ready = 1):
- A move is legal when move_valid = 1, move_idx is in 1..9, and the addressed cell is 0.
- On a legal move, in the same edge:
  - write turn into the cell;
  - increment move_count;
  - clear the timeout counter;
  - go to CHECK.
- Illegal request (move_idx 0 or 10..15, or cell occupied):
  - illegal_move = 1 for exactly the next cycle;
  - no state change; stay in PLAY;
  - timeout counter keeps counting.
- Timeout:
  - if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with no legal move that cycle, then toggle turn (1↔2), pulse timeout for one cycle, clear the counter, stay in PLAY;
  - a legal move in that same cycle wins over the timeout.

CHECK (move_ready = 0; move_valid ignored, no illegal_move pulse):
- The board is registered, so win_in/who_in here reflect the updated board. Latency is one cycle from the accept edge to the decision edge.
- If win_in: winner <= who_in, game_over <= 1, go to DONE.
- Else if move_count == 9: draw <= 1, game_over <= 1, go to DONE.
- Else: toggle turn, go to PLAY.
- A win on the 9th move is a win, not a draw.

DONE (move_ready = 0):
- Board, winner and draw are held.
- Moves are ignored; no illegal_move pulse; turn is frozen.

new_game (any state):
- Next edge applies the same values as reset and goes to PLAY.
- Has priority over move_valid in the same cycle; that move is discarded.

Other rules:
- win_in is ignored outside CHECK.
- Turn toggling uses 1↔2 only.
- rst_n assertion mid-game clears everything immediately, regardless of clock.
- move_count saturates at 9; it cannot exceed 9 by construction.

Test Plan:
- Reset, then legal moves X@1, O@4, X@2, O@5, X@3 (winner_detector attached) → after the 5th accept, CHECK sees win_in=1, who_in=1. Required: winner=1, game_over=1, move_count=5, pos1..3=1, pos4..5=2, move_ready=0.
- Move to occupied cell 1 after X@1, and a request with move_idx=0 → illegal_move pulses once each; board and turn (2) unchanged; move_count=1.
- Nine legal moves with no line (X:1,3,4,8,9? no — use X:1,2,6,7,9 / O:3,4,5,8 ordered X1 O3 X2 O5 X7 O4 X6 O8 X9) → draw=1, winner=0, game_over=1, move_count=9.
- TIMEOUT_CYCLES=4, no moves after reset → timeout pulses at cycles 4, 8 after reset release; turn goes 1→2→1; board all 0.
- move_valid held high during CHECK and DONE → no writes, no illegal_move; new_game asserted together with move_valid in DONE → board all 0, turn=FIRST_PLAYER, game_over=0, move_count=0.
- rst_n pulled low between clock edges mid-game (move_count=3) → all outputs reach reset values without a clock edge; play resumes from PLAY after release.
